// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per clock behind a start/done
// handshake, with a division-by-zero flag and data-independent latency.
module seq_divider #(
    parameter int N = 6,
    parameter int M = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [M-1:0] divisor,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [M-1:0] remainder,
    output logic         div_zero
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  d_q, d_d;
    logic [M-1:0]  v_q, v_d;
    logic [M:0]    p_q, p_d;
    logic [N-1:0]  q_q, q_d;
    logic [CW-1:0] count_q, count_d;
    logic          dz_q, dz_d;
    logic [N-1:0]  quotient_q, quotient_d;
    logic [M-1:0]  remainder_q, remainder_d;
    logic          div_zero_q, div_zero_d;

    logic          accept_s;
    logic [M:0]    t_s;
    logic [M:0]    diff_s;
    logic          qbit_s;
    logic [M:0]    p_next_s;
    logic [N-1:0]  q_next_s;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            d_q         <= {N{1'b0}};
            v_q         <= {M{1'b0}};
            p_q         <= {(M+1){1'b0}};
            q_q         <= {N{1'b0}};
            count_q     <= CNT_ZERO;
            dz_q        <= 1'b0;
            quotient_q  <= {N{1'b0}};
            remainder_q <= {M{1'b0}};
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            d_q         <= d_d;
            v_q         <= v_d;
            p_q         <= p_d;
            q_q         <= q_d;
            count_q     <= count_d;
            dz_q        <= dz_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CALC;
                else       state_d = S_IDLE;
            end
            S_CALC: begin
                if (count_q == CNT_ZERO) state_d = S_DONE;
                else                     state_d = S_CALC;
            end
            S_DONE: begin
                if (start) state_d = S_CALC;
                else       state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // One restoring step; a zero divisor forces every trial subtraction to fail
    always_comb begin
        accept_s = start && ((state_q == S_IDLE) || (state_q == S_DONE));
        t_s      = {p_q[M-1:0], d_q[N-1]};
        diff_s   = t_s - {1'b0, v_q};
        qbit_s   = !dz_q && (t_s >= {1'b0, v_q});
        p_next_s = qbit_s ? diff_s : t_s;
        q_next_s = {q_q[N-2:0], qbit_s};
    end

    // Datapath updates: operand capture on accept, iteration in CALC
    always_comb begin
        d_d         = d_q;
        v_d         = v_q;
        p_d         = p_q;
        q_d         = q_q;
        count_d     = count_q;
        dz_d        = dz_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        if (accept_s) begin
            d_d         = dividend;
            v_d         = divisor;
            p_d         = {(M+1){1'b0}};
            q_d         = {N{1'b0}};
            count_d     = CNT_LAST;
            dz_d        = (divisor == {M{1'b0}});
            quotient_d  = {N{1'b0}};
            remainder_d = {M{1'b0}};
            div_zero_d  = 1'b0;
        end else if (state_q == S_CALC) begin
            d_d = {d_q[N-2:0], 1'b0};
            p_d = p_next_s;
            q_d = q_next_s;
            if (count_q == CNT_ZERO) begin
                count_d = CNT_ZERO;
                if (dz_q) begin
                    quotient_d  = {N{1'b1}};
                    remainder_d = {M{1'b0}};
                    div_zero_d  = 1'b1;
                end else begin
                    quotient_d  = q_next_s;
                    remainder_d = p_next_s[M-1:0];
                    div_zero_d  = 1'b0;
                end
            end else begin
                count_d = count_q - CNT_ONE;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Outputs decoded from registered state and result registers
    always_comb begin
        ready     = (state_q != S_CALC);
        busy      = (state_q == S_CALC);
        done      = (state_q == S_DONE);
        quotient  = quotient_q;
        remainder = remainder_q;
        div_zero  = div_zero_q;
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results computed
// with plain integer division, a monitor pops and compares on every done.
module tb_seq_divider;

    localparam int N   = 6;
    localparam int M   = 3;
    localparam int LAT = N;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] dividend;
    logic [M-1:0] divisor;
    logic         ready;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [M-1:0] remainder;
    logic         div_zero;

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int dz;
        int acc;
    } exp_t;

    exp_t sb[$];
    int   tests  = 0;
    int   failed = 0;
    int   cyc    = 0;

    seq_divider #(.N(N), .M(M)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare every presented result against the scoreboard head
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            chk("busy_is_not_ready", {31'd0, busy}, {31'd0, ~ready});
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("quotient", {26'd0, quotient}, e.q);
                    chk("remainder", {29'd0, remainder}, e.r);
                    chk("div_zero", {31'd0, div_zero}, e.dz);
                    chk("latency", cyc - e.acc, LAT);
                    if (e.dz == 0) begin
                        chk("identity", quotient * e.b + remainder, e.a);
                        chk("rem_lt_div", {31'd0, (remainder < e.b)}, 32'd1);
                    end
                end
            end
        end
    end

    // Issue one operation from a negedge, waiting (bounded) for ready
    task automatic do_op(input int a, input int b);
        int   guard;
        exp_t e;
        guard = 0;
        while (ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("ready_timeout", 32'd0, 32'd1);
        start    = 1'b1;
        dividend = N'(a);
        divisor  = M'(b);
        e.a   = a;
        e.b   = b;
        e.dz  = (b == 0) ? 1 : 0;
        e.q   = (b == 0) ? ((1 << N) - 1) : a / b;
        e.r   = (b == 0) ? 0 : a % b;
        e.acc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        chk("cleared_quotient", {26'd0, quotient}, 32'd0);
        chk("cleared_remainder", {29'd0, remainder}, 32'd0);
        chk("cleared_div_zero", {31'd0, div_zero}, 32'd0);
    endtask

    initial begin
        int guard;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_quotient", {26'd0, quotient}, 32'd0);
        chk("rst_remainder", {29'd0, remainder}, 32'd0);
        chk("rst_div_zero", {31'd0, div_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(50, 7);
        do_op(63, 7);
        do_op(6, 7);
        do_op(63, 1);
        do_op(37, 0);
        do_op(20, 3);

        // A start pulse mid-calculation must be ignored
        do_op(45, 5);
        @(negedge clk);
        start    = 1'b1;
        dividend = 6'd10;
        divisor  = 3'd2;
        @(negedge clk);
        start = 1'b0;
        chk("ignored_start_busy", {31'd0, busy}, 32'd1);
        chk("ignored_start_quotient", {26'd0, quotient}, 32'd0);
        do_op(10, 2);

        // Reset on the third CALC cycle abandons the operation
        do_op(50, 7);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        chk("midrst_ready", {31'd0, ready}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_quotient", {26'd0, quotient}, 32'd0);
        chk("midrst_div_zero", {31'd0, div_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(12, 5);

        for (int i = 0; i < 40; i++) begin
            do_op(int'($urandom_range(63)), int'($urandom_range(7)));
        end

        for (int a = 0; a < 64; a++) begin
            for (int b = 1; b < 8; b++) begin
                do_op(a, b);
            end
        end

        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_scoreboard", sb.size(), 32'd0);
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative restoring divider that inverts the team's 3x3 array multiplier: it takes a 6-bit dividend and a 3-bit divisor and returns quotient and remainder, with dividend = quotient × divisor + remainder. It is the sequential, area-light companion to the combinational multiplier. It retires one quotient bit per clock behind a start/done handshake, and it flags division by zero.

## Interface
- N, default 6: dividend and quotient width.
- M, default 3: divisor and remainder width; M ≤ N.
- clk  input  1: single clock; all state updates on the rising edge.
- rst_n  input  1: asynchronous, active-low reset; synchronous deassertion is the integrator's responsibility.
- start  input  1: request; sampled only when ready = 1.
- dividend  input  N: unsigned; sampled with an accepted start.
- divisor  input  M: unsigned; sampled with an accepted start.
- ready  output  1: high in IDLE and DONE; low in CALC.
- busy  output  1: equals ~ready.
- done  output  1: one-cycle pulse when results become valid.
- quotient  output  N: unsigned quotient; held until the next accepted start.
- remainder  output  M: unsigned remainder; held until the next accepted start.
- div_zero  output  1: set with done when the latched divisor = 0; held with the results.

## Operation
- States:
  - IDLE: reset state.
  - CALC: iterating.
  - DONE: results valid, done = 1.
- IDLE, start = 1: latch dividend into shift register D and divisor into V; clear partial remainder P (M+1 bits); set count = N−1; set dz = (divisor == 0); go to CALC. Clear quotient, remainder, div_zero on accept.
- CALC, each cycle:
  - T = {P[M−1:0], D[N−1]}; D shifts left by 1.
  - If dz = 0 and T ≥ {1'b0, V}: P = T − V, and the quotient bit is 1.
  - Otherwise P = T, and the quotient bit is 0.
  - Quotient bits enter the LSB of the quotient shift register, MSB first.
- CALC with count = 0: perform the last iteration, then load the outputs:
  - dz = 0: quotient = final quotient, remainder = P[M−1:0].
  - dz = 1: quotient = all ones, remainder = 0, div_zero = 1.
  - Go to DONE.
- DONE: done = 1 for exactly this cycle.
  - start = 1: accepted exactly as from IDLE (back-to-back operation); go to CALC.
  - Otherwise go to IDLE.
- start while in CALC: ignored; no effect on state, operands, or outputs. Operand changes during CALC are also ignored.
- P never exceeds M+1 bits: P < V ≤ 2^M − 1, so T < 2^(M+1).
- Division by zero takes the same N-cycle latency as a normal operation; latency is data-independent.

## Timing
- Reset (asynchronous, immediate): state = IDLE, ready = 1, busy = 0, done = 0, quotient = 0, remainder = 0, div_zero = 0, count = 0.
- Start accepted at edge E0: busy = 1 after E0.
  - Iterations run at edges E1..EN.
  - Results and done are visible after edge EN.
  - done falls after EN+1.
- Latency from the accepting edge to done: N cycles (6 at the defaults).
- Throughput with back-to-back starts in DONE: one result every N+1 cycles.
- Reset asserted mid-CALC: the operation is abandoned, all outputs return to reset values, no done is produced, and the next start after release begins a clean operation.
- Outputs change only at the result edge, at the accepting edge (cleared), or on reset.

## Test plan
- Reset, then start with dividend = 50, divisor = 7 -> 6 cycles later done = 1, quotient = 7, remainder = 1, div_zero = 0; ready = 0 for exactly 6 cycles.
- dividend = 63, divisor = 7 -> quotient = 9, remainder = 0. dividend = 6, divisor = 7 -> quotient = 0, remainder = 6. dividend = 63, divisor = 1 -> quotient = 63, remainder = 0.
- dividend = 37, divisor = 0 -> done after 6 cycles, quotient = 63, remainder = 0, div_zero = 1. The next operation, 20/3, clears div_zero on accept and yields quotient = 6, remainder = 2.
- Start 45/5; pulse start with 10/2 during CALC -> the second request is ignored, result is quotient = 9, remainder = 0. Then assert start in the DONE cycle with 10/2 -> accepted, done 6 cycles later with quotient = 5, remainder = 0.
- Start 50/7; assert rst_n = 0 on the third CALC cycle -> outputs immediately return to 0, no done pulse. After release, 12/5 -> quotient = 2, remainder = 2.
- Exhaustive sweep over all 64 × 7 nonzero operand pairs, back-to-back -> for every pair, quotient × divisor + remainder == dividend and remainder < divisor.
